// File: rtl/rob_if.sv
// -----------------------------------------------------------------------------
// rob_if
// Purpose:
//   Groups every handshake and data bus of the reorder buffer into one bundle.
//   These are the decoder dispatch port, the two CDB writeback ports, the
//   operand query ports, the register-file commit port, the store-commit
//   strobe and the flush/redirect pair.
//   Clock, reset and the global ready enable stay as plain ports on the ROB.
// Parameters:
//   W  tag width; the all-ones tag means "no dependency".
// Signals (direction seen from the ROB, i.e. the slave modport):
//   dec_valid/dec_type/dec_rd/dec_pred_pc       in   dispatch request
//   full_out/tail_out                           out  free-entry status, next tag
//   alu_valid/alu_rob/alu_value/alu_next_pc     in   ALU CDB
//   lsb_valid/lsb_rob/lsb_value                 in   LSB CDB
//   qry1_idx/qry2_idx                           in   operand tag lookups
//   qry1_ready/qry1_value/qry2_ready/qry2_value out  lookup results
//   rob_valid/rob_rd/rob_value/rob_dependency   out  register-file commit
//   store_commit_out/store_rob_out              out  store may write memory
//   need_flush_out/redirect_pc_out              out  mispredict flush + new PC
// -----------------------------------------------------------------------------
interface rob_if #(
  parameter int W = 4
);
  logic          dec_valid;
  logic [1:0]    dec_type;
  logic [4:0]    dec_rd;
  logic [31:0]   dec_pred_pc;
  logic          full_out;
  logic [W-1:0]  tail_out;

  logic          alu_valid;
  logic [W-1:0]  alu_rob;
  logic [31:0]   alu_value;
  logic [31:0]   alu_next_pc;

  logic          lsb_valid;
  logic [W-1:0]  lsb_rob;
  logic [31:0]   lsb_value;

  logic [W-1:0]  qry1_idx;
  logic [W-1:0]  qry2_idx;
  logic          qry1_ready;
  logic [31:0]   qry1_value;
  logic          qry2_ready;
  logic [31:0]   qry2_value;

  logic          rob_valid;
  logic [4:0]    rob_rd;
  logic [31:0]   rob_value;
  logic [W-1:0]  rob_dependency;

  logic          store_commit_out;
  logic [W-1:0]  store_rob_out;

  logic          need_flush_out;
  logic [31:0]   redirect_pc_out;

  // The environment side: decoder, execution units and register file together
  modport master (
    output dec_valid, dec_type, dec_rd, dec_pred_pc,
    input  full_out, tail_out,
    output alu_valid, alu_rob, alu_value, alu_next_pc,
    output lsb_valid, lsb_rob, lsb_value,
    output qry1_idx, qry2_idx,
    input  qry1_ready, qry1_value, qry2_ready, qry2_value,
    input  rob_valid, rob_rd, rob_value, rob_dependency,
    input  store_commit_out, store_rob_out,
    input  need_flush_out, redirect_pc_out
  );

  // The reorder buffer itself
  modport slave (
    input  dec_valid, dec_type, dec_rd, dec_pred_pc,
    output full_out, tail_out,
    input  alu_valid, alu_rob, alu_value, alu_next_pc,
    input  lsb_valid, lsb_rob, lsb_value,
    input  qry1_idx, qry2_idx,
    output qry1_ready, qry1_value, qry2_ready, qry2_value,
    output rob_valid, rob_rd, rob_value, rob_dependency,
    output store_commit_out, store_rob_out,
    output need_flush_out, redirect_pc_out
  );
endinterface

// File: rtl/rob.sv
// -----------------------------------------------------------------------------
// rob
// Purpose:
//   Reorder buffer. It is a circular queue of in-flight instructions that sits
//   between dispatch and the register file.
//   Each dispatched instruction gets a tag. Results arrive from the ALU and LSB
//   CDBs. Entries retire strictly in order, at most one per cycle. A BRANCH
//   whose resolved next PC differs from the predicted one raises a one-cycle
//   flush together with the corrected PC, and the queue is emptied.
// Parameters:
//   ROB_SIZE_WIDTH  tag width W. 2**W-1 usable entries; the all-ones tag is
//                   reserved as "no dependency" and is never allocated.
// Ports:
//   clk_in   in  clock
//   rst_in   in  synchronous active-high reset, wins over rdy_in
//   rdy_in   in  global enable; low freezes all state and registered outputs
//   bus      rob_if.slave, which carries dispatch, CDBs, queries, commit,
//            store commit and flush/redirect
// -----------------------------------------------------------------------------
module rob #(
  parameter int ROB_SIZE_WIDTH = 4
) (
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  rdy_in,
  rob_if.slave  bus
);

  localparam int W         = ROB_SIZE_WIDTH;
  localparam int ROB_DEPTH = 2 ** W;
  localparam int ROB_SIZE  = ROB_DEPTH - 1;

  localparam logic [W-1:0] LAST_TAG   = W'(ROB_SIZE - 1);
  localparam logic [W-1:0] NO_DEP     = '1;
  localparam logic [W-1:0] FULL_COUNT = W'(ROB_SIZE);

  typedef enum logic [1:0] {
    TYPE_REG    = 2'd0,
    TYPE_STORE  = 2'd1,
    TYPE_BRANCH = 2'd2,
    TYPE_RSVD   = 2'd3
  } entry_type_e;

  // Storage is 2**W deep so any W-bit tag indexes it safely. The all-ones
  // slot is never allocated, so its busy bit stays clear. CDB writes and
  // queries that carry that tag therefore fall through harmlessly.
  logic         r_busy    [ROB_DEPTH];
  logic         r_ready   [ROB_DEPTH];
  entry_type_e  r_type    [ROB_DEPTH];
  logic [4:0]   r_rd      [ROB_DEPTH];
  logic [31:0]  r_value   [ROB_DEPTH];
  logic [31:0]  r_predPc  [ROB_DEPTH];
  logic [31:0]  r_nextPc  [ROB_DEPTH];

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [W-1:0] r_count;

  logic         r_robValid;
  logic [4:0]   r_robRd;
  logic [31:0]  r_robValue;
  logic [W-1:0] r_robDependency;
  logic         r_storeCommit;
  logic [W-1:0] r_storeRob;
  logic         r_needFlush;
  logic [31:0]  r_redirectPc;

  logic         w_full;
  logic         w_dispatch;
  logic         w_commit;
  logic         w_headIsStore;
  logic         w_mispredict;
  logic         w_aluWrite;
  logic         w_lsbWrite;
  logic         w_qry1Ready;
  logic [31:0]  w_qry1Value;
  logic         w_qry2Ready;
  logic [31:0]  w_qry2Value;

  // Tags run 0..ROB_SIZE-1 and wrap before reaching the reserved all-ones tag
  function automatic logic [W-1:0] nextTag(input logic [W-1:0] tag);
    return (tag == LAST_TAG) ? '0 : tag + 1'b1;
  endfunction

  // Full status comes from the registered count only. A commit on the same
  // edge does not open a slot for this cycle's dispatch.
  // Only the head entry is ever examined for retirement. A mispredict is a
  // retiring BRANCH whose resolved next PC disagrees with the fetcher's guess.
  always_comb begin
    w_full        = (r_count == FULL_COUNT);
    w_dispatch    = bus.dec_valid & ~w_full;
    w_commit      = r_busy[r_head] & r_ready[r_head];
    w_headIsStore = (r_type[r_head] == TYPE_STORE);
    w_mispredict  = w_commit && (r_type[r_head] == TYPE_BRANCH) &&
                    (r_nextPc[r_head] != r_predPc[r_head]);
    w_aluWrite    = bus.alu_valid & r_busy[bus.alu_rob];
    w_lsbWrite    = bus.lsb_valid & r_busy[bus.lsb_rob];
  end

  // Operand lookups for the decoder. A result on a CDB in the same cycle is
  // forwarded, so the decoder never misses a value that is being written
  // back right now. Otherwise the entry supplies it once it is marked ready.
  always_comb begin
    w_qry1Ready = r_busy[bus.qry1_idx] & r_ready[bus.qry1_idx];
    w_qry1Value = r_value[bus.qry1_idx];
    if (bus.alu_valid && (bus.alu_rob == bus.qry1_idx)) begin
      w_qry1Ready = 1'b1;
      w_qry1Value = bus.alu_value;
    end else if (bus.lsb_valid && (bus.lsb_rob == bus.qry1_idx)) begin
      w_qry1Ready = 1'b1;
      w_qry1Value = bus.lsb_value;
    end

    w_qry2Ready = r_busy[bus.qry2_idx] & r_ready[bus.qry2_idx];
    w_qry2Value = r_value[bus.qry2_idx];
    if (bus.alu_valid && (bus.alu_rob == bus.qry2_idx)) begin
      w_qry2Ready = 1'b1;
      w_qry2Value = bus.alu_value;
    end else if (bus.lsb_valid && (bus.lsb_rob == bus.qry2_idx)) begin
      w_qry2Ready = 1'b1;
      w_qry2Value = bus.lsb_value;
    end
  end

  // Queue state and all registered outputs are updated here.
  // Priority order is reset, then the global enable, then a mispredict, which
  // empties everything. After that comes the flush cycle, in which new
  // dispatches and CDB results belong to the squashed path and are dropped.
  // Normal operation comes last.
  // Commit strobes are pulses. They clear on every enabled edge unless a new
  // commit sets them again.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_robValid      <= 1'b0;
      r_robRd         <= '0;
      r_robValue      <= '0;
      r_robDependency <= NO_DEP;
      r_storeCommit   <= 1'b0;
      r_storeRob      <= '0;
      r_needFlush     <= 1'b0;
      r_redirectPc    <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_busy[i]  <= 1'b0;
        r_ready[i] <= 1'b0;
      end
    end else if (rdy_in) begin
      r_robValid    <= 1'b0;
      r_storeCommit <= 1'b0;
      r_needFlush   <= 1'b0;

      // A store retiring only lets the LSB write memory. Every other type
      // retires through the register-file port. A mispredicting branch still
      // writes its link value.
      if (w_commit) begin
        if (w_headIsStore) begin
          r_storeCommit <= 1'b1;
          r_storeRob    <= r_head;
        end else begin
          r_robValid      <= 1'b1;
          r_robRd         <= r_rd[r_head];
          r_robValue      <= r_value[r_head];
          r_robDependency <= r_head;
        end
      end

      if (w_mispredict) begin
        r_needFlush  <= 1'b1;
        r_redirectPc <= r_nextPc[r_head];
        r_head       <= '0;
        r_tail       <= '0;
        r_count      <= '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
          r_busy[i]  <= 1'b0;
          r_ready[i] <= 1'b0;
        end
      end else if (!r_needFlush) begin
        if (w_aluWrite) begin
          r_value[bus.alu_rob]  <= bus.alu_value;
          r_nextPc[bus.alu_rob] <= bus.alu_next_pc;
          r_ready[bus.alu_rob]  <= 1'b1;
        end
        if (w_lsbWrite) begin
          r_value[bus.lsb_rob] <= bus.lsb_value;
          r_ready[bus.lsb_rob] <= 1'b1;
        end

        if (w_commit) begin
          r_busy[r_head] <= 1'b0;
          r_head         <= nextTag(r_head);
        end

        // The dispatch write comes after the CDB writes. Because full refuses
        // dispatch, the tail slot is never busy, so no CDB write can hit it.
        if (w_dispatch) begin
          r_busy[r_tail]   <= 1'b1;
          r_ready[r_tail]  <= 1'b0;
          r_type[r_tail]   <= entry_type_e'(bus.dec_type);
          r_rd[r_tail]     <= bus.dec_rd;
          r_predPc[r_tail] <= bus.dec_pred_pc;
          r_tail           <= nextTag(r_tail);
        end

        unique case ({w_dispatch, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign bus.full_out         = w_full;
  assign bus.tail_out         = r_tail;
  assign bus.qry1_ready       = w_qry1Ready;
  assign bus.qry1_value       = w_qry1Value;
  assign bus.qry2_ready       = w_qry2Ready;
  assign bus.qry2_value       = w_qry2Value;
  assign bus.rob_valid        = r_robValid;
  assign bus.rob_rd           = r_robRd;
  assign bus.rob_value        = r_robValue;
  assign bus.rob_dependency   = r_robDependency;
  assign bus.store_commit_out = r_storeCommit;
  assign bus.store_rob_out    = r_storeRob;
  assign bus.need_flush_out   = r_needFlush;
  assign bus.redirect_pc_out  = r_redirectPc;

endmodule
